// File: rtl/labk_pkg.sv
// Shared types and constants for the lab-kit mux z collector.
package labk_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collect_state_t;

    localparam int unsigned LABK_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_index_counter.sv
// Bit-position counter for the collector: advances on enable, wraps to 0 after WIDTH-1.
module bit_index_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    output logic [$clog2(WIDTH)-1:0]   idx,
    output logic                       atLast_c
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    assign atLast_c = (idx == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (en) begin
            idx <= atLast_c ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mux_z_collector.sv
// Collects WIDTH mux z samples LSB-first and offers them as one word on a valid/ready port.
// Optional MUX_ONES_COUNT_EN adds out_ones, the population count of out_word.
module mux_z_collector
    import labk_pkg::*;
#(
    parameter int unsigned WIDTH = LABK_DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          z_in,
    input  logic                          z_valid,
    output logic                          z_ready,
    output logic [WIDTH-1:0]              out_word,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef MUX_ONES_COUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0]    out_ones
`endif
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    collect_state_t state;
    logic [IDX_W-1:0] idx;
    logic             atLast;
    logic             accept;

    // z_ready is a pure decode of the state register, so it drops the cycle HOLD is entered.
    assign z_ready = (state == COLLECT);
    assign accept  = z_valid && (state == COLLECT);

    bit_index_counter #(
        .WIDTH    (WIDTH)
    ) uIdx (
        .clk      (clk),
        .reset    (reset),
        .en       (accept),
        .idx      (idx),
        .atLast_c (atLast)
    );

    // Word FSM: fill in COLLECT, present and wait for the consumer in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (z_valid) begin
                        out_word[idx] <= z_in;
                        if (atLast) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_ONES_COUNT_EN
    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    // The first bit of each word restarts the count instead of accumulating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ones <= '0;
        end else if (accept) begin
            if (idx == IDX_W'(0)) begin
                out_ones <= ONES_W'(z_in);
            end else begin
                out_ones <= out_ones + ONES_W'(z_in);
            end
        end
    end
`endif

endmodule
